// File: rtl/atm_session_ctrl.sv
// ATM session sequencer: card/PIN handling, ledger command dispatch and status reporting.
// Optional idle timeout in PIN/MENU/NEXT is enabled by defining TIMEOUT_EN.
module atm_session_ctrl #(
    parameter int PIN_W       = 4,
    parameter int AMT_W       = 7,
    parameter int BAL_W       = 32,
    parameter int MAX_TRIES   = 3,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cardIn,
    input  logic             ejectCard,
    input  logic             pin_valid,
    input  logic [PIN_W-1:0] password,
    input  logic [PIN_W-1:0] pin_ref,
    input  logic             op_valid,
    input  logic [1:0]       opCode,
    input  logic [AMT_W-1:0] inputAmount,
    input  logic             moneyDeposited,
    input  logic             Another_Operation,
    output logic             ledger_req,
    output logic [1:0]       ledger_op,
    output logic [AMT_W-1:0] ledger_amt,
    input  logic             ledger_ack,
    input  logic             ledger_ok,
    input  logic [BAL_W-1:0] ledger_bal,
    output logic             correctPassword,
    output logic [BAL_W-1:0] Current_Balance,
    output logic             Balance_Shown,
    output logic             Deposited_Successfully,
    output logic             Withdrawed_Successfully,
    output logic             op_reject,
    output logic             ATM_Usage_Finished,
    output logic             card_retained
);

    localparam int TRY_W = $clog2(MAX_TRIES + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PIN    = 3'd1,
        S_MENU   = 3'd2,
        S_EXEC   = 3'd3,
        S_NEXT   = 3'd4,
        S_DONE   = 3'd5,
        S_LOCKED = 3'd6
    } state_t;

    state_t           state_r, state_s;
    logic [TRY_W-1:0] tries_r, tries_s;
    logic             eject_pend_r, eject_pend_s;
    logic             card_gone_r, card_gone_s;
    logic             req_s, bal_load_s;
    logic [1:0]       op_s;
    logic [AMT_W-1:0] amt_s;
    logic             shown_s, dep_s, wd_s, rej_s;
    logic             timeout_s;
    logic             waiting_s;

    assign waiting_s = (state_r == S_PIN) || (state_r == S_MENU) || (state_r == S_NEXT);

`ifdef TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt_r;

    // Idle counter: restarts on any state change or user strobe, frozen outside wait states
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if ((state_s != state_r) || pin_valid || op_valid) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if (waiting_s && !timeout_s) begin
            tmo_cnt_r <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    assign timeout_s = waiting_s && (tmo_cnt_r == TMO_W'(TIMEOUT_CYC - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state and next-output decode
    always_comb begin
        state_s      = state_r;
        tries_s      = tries_r;
        eject_pend_s = eject_pend_r;
        card_gone_s  = card_gone_r;
        req_s        = 1'b0;
        op_s         = ledger_op;
        amt_s        = ledger_amt;
        bal_load_s   = 1'b0;
        shown_s      = 1'b0;
        dep_s        = 1'b0;
        wd_s         = 1'b0;
        rej_s        = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (cardIn) begin
                    state_s = S_PIN;
                    tries_s = {TRY_W{1'b0}};
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_PIN: begin
                if (!cardIn) begin
                    state_s = S_IDLE;
                end else if (ejectCard) begin
                    state_s = S_DONE;
                end else if (pin_valid) begin
                    if (password == pin_ref) begin
                        state_s = S_MENU;
                    end else if (tries_r >= TRY_W'(MAX_TRIES - 1)) begin
                        tries_s = TRY_W'(MAX_TRIES);
                        state_s = S_LOCKED;
                    end else begin
                        tries_s = tries_r + {{(TRY_W-1){1'b0}}, 1'b1};
                    end
                end else if (timeout_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_PIN;
                end
            end
            S_MENU: begin
                if (!cardIn) begin
                    state_s = S_IDLE;
                end else if (ejectCard) begin
                    state_s = S_DONE;
                end else if (op_valid) begin
                    case (opCode)
                        2'b11: state_s = S_DONE;
                        2'b00: begin
                            state_s = S_EXEC;
                            req_s   = 1'b1;
                            op_s    = 2'b00;
                            amt_s   = {AMT_W{1'b0}};
                        end
                        2'b01: begin
                            if (moneyDeposited && (inputAmount != {AMT_W{1'b0}})) begin
                                state_s = S_EXEC;
                                req_s   = 1'b1;
                                op_s    = 2'b01;
                                amt_s   = inputAmount;
                            end else begin
                                rej_s = 1'b1;
                            end
                        end
                        2'b10: begin
                            if (inputAmount != {AMT_W{1'b0}}) begin
                                state_s = S_EXEC;
                                req_s   = 1'b1;
                                op_s    = 2'b10;
                                amt_s   = inputAmount;
                            end else begin
                                rej_s = 1'b1;
                            end
                        end
                        default: rej_s = 1'b1;
                    endcase
                    eject_pend_s = 1'b0;
                    card_gone_s  = 1'b0;
                end else if (timeout_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_MENU;
                end
            end
            S_EXEC: begin
                // Exit requests are remembered and honoured once the ledger answers
                eject_pend_s = eject_pend_r | ejectCard;
                card_gone_s  = card_gone_r | !cardIn;
                if (ledger_ack) begin
                    bal_load_s = 1'b1;
                    case (ledger_op)
                        2'b00:   shown_s = 1'b1;
                        2'b01:   dep_s   = 1'b1;
                        2'b10: begin
                            if (ledger_ok) begin
                                wd_s = 1'b1;
                            end else begin
                                rej_s = 1'b1;
                            end
                        end
                        default: rej_s = 1'b1;
                    endcase
                    if (card_gone_s) begin
                        state_s = S_IDLE;
                    end else if (eject_pend_s) begin
                        state_s = S_DONE;
                    end else begin
                        state_s = S_NEXT;
                    end
                end else begin
                    req_s = 1'b1;
                end
            end
            S_NEXT: begin
                if (!cardIn) begin
                    state_s = S_IDLE;
                end else if (ejectCard) begin
                    state_s = S_DONE;
                end else if (op_valid) begin
                    state_s = Another_Operation ? S_MENU : S_DONE;
                end else if (timeout_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_NEXT;
                end
            end
            S_DONE: begin
                state_s = cardIn ? S_DONE : S_IDLE;
            end
            S_LOCKED: begin
                state_s = S_LOCKED;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r                 <= S_IDLE;
            tries_r                 <= {TRY_W{1'b0}};
            eject_pend_r            <= 1'b0;
            card_gone_r             <= 1'b0;
            ledger_req              <= 1'b0;
            ledger_op               <= 2'b00;
            ledger_amt              <= {AMT_W{1'b0}};
            correctPassword         <= 1'b0;
            Current_Balance         <= {BAL_W{1'b0}};
            Balance_Shown           <= 1'b0;
            Deposited_Successfully  <= 1'b0;
            Withdrawed_Successfully <= 1'b0;
            op_reject               <= 1'b0;
            ATM_Usage_Finished      <= 1'b0;
            card_retained           <= 1'b0;
        end else begin
            state_r                 <= state_s;
            tries_r                 <= tries_s;
            eject_pend_r            <= eject_pend_s;
            card_gone_r             <= card_gone_s;
            ledger_req              <= req_s;
            ledger_op               <= op_s;
            ledger_amt              <= amt_s;
            correctPassword         <= (state_s == S_MENU) || (state_s == S_EXEC) || (state_s == S_NEXT);
            Current_Balance         <= bal_load_s ? ledger_bal : Current_Balance;
            Balance_Shown           <= shown_s;
            Deposited_Successfully  <= dep_s;
            Withdrawed_Successfully <= wd_s;
            op_reject               <= rej_s;
            ATM_Usage_Finished      <= (state_s == S_DONE) && (state_r != S_DONE);
            card_retained           <= (state_s == S_LOCKED);
        end
    end

endmodule
